// File: rtl/wide_add_seq.sv
// Word-serial multi-precision adder: chains carry across WORDS 32-bit words through an external adder.
// Latency: one cycle from the accept edge to out_valid/out_sum; one word per cycle while drained.
// Backpressure: single output register; in_ready drops while a result is held and out_ready is low.
module wide_add_seq #(
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sync_clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    input  logic [31:0] add_sum,
    input  logic        add_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_sum,
    output logic        out_last,
    output logic        out_cout,
    output logic        out_ovf,
    output logic        out_zero
);

    localparam int IW = (WORDS > 2) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    logic [IW-1:0] idx;
    logic          cy;
    logic          zacc;

    logic          accept;
    logic          cin;
    logic [31:0]   w;
    logic          c;
    logic          c31;
    logic          ovf;
    logic          is_first;
    logic          is_last;
    logic          zero_so_far;

    // The adder sits outside this block; operands go straight through to it.
    assign add_a = in_a;
    assign add_b = in_b;

    // Handshake: the output register is the only storage, so accept only when it is free or draining.
    assign in_ready = !sync_clr && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Fold the chained carry into the adder's result; word 0 never sees a carry-in.
    always_comb begin
        is_first    = (idx == '0);
        is_last     = (idx == LAST_IDX);
        cin         = is_first ? 1'b0 : cy;
        w           = add_sum + {31'b0, cin};
        c           = add_cout | (cin & (&add_sum));
        c31         = in_a[31] ^ in_b[31] ^ w[31];
        ovf         = c31 ^ c;
        zero_so_far = (is_first ? 1'b1 : zacc) & (w == 32'h0);
    end

    // Word counter, carry chain, zero accumulator and the registered result stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            cy        <= 1'b0;
            zacc      <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= 32'h0;
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
        end else if (sync_clr) begin
            idx       <= '0;
            cy        <= 1'b0;
            zacc      <= 1'b1;
            out_valid <= 1'b0;
            out_sum   <= 32'h0;
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_sum   <= w;
            if (is_last) begin
                out_last <= 1'b1;
                out_cout <= c;
                out_ovf  <= ovf;
                out_zero <= zero_so_far;
                idx      <= '0;
                cy       <= 1'b0;
                zacc     <= 1'b1;
            end else begin
                out_last <= 1'b0;
                out_cout <= 1'b0;
                out_ovf  <= 1'b0;
                out_zero <= 1'b0;
                idx      <= idx + IW'(1);
                cy       <= c;
                zacc     <= zero_so_far;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
